svm_accum_ctrl: RTL and testbench

Sequencer for the SVM dot-product accumulation stage. On `start`, it walks every support vector (SV) and, within each SV, every feature index. For each it:
- issues MAC operations,
- waits out the MAC pipeline,
- pulses the accumulator stage enable,
- captures the accumulated kernel partial and hands it downstream over a valid/ready port.

It sits between the top-level classifier FSM and the multiplier/accumulator datapath.

---
 rtl/svm_accum_ctrl.sv | 155 +++++++++++++++
 tb/tb_svm_accum_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/svm_accum_ctrl.sv
// Sequencer for the SVM dot-product accumulation stage: walks SVs x features, drains the MAC pipe,
// pulses the accumulator stage and hands each SV partial downstream. Define SVM_ACCUM_CTRL_WDOG_EN for the WAIT_ACC watchdog (err output).
module svm_accum_ctrl #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_FEAT   = 16,
  parameter  int NUM_SV     = 8,
  parameter  int MAC_LAT    = 2,
  localparam int FEAT_W     = $clog2(NUM_FEAT + 1),
  localparam int FEAT_AW    = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1,
  localparam int SV_W       = $clog2(NUM_SV + 1),
  localparam int SV_AW      = (NUM_SV > 1) ? $clog2(NUM_SV) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FEAT_W-1:0]     cfg_num_feat,
  input  logic [SV_W-1:0]       cfg_num_sv,
  output logic                  busy,
  output logic                  done,
  output logic [FEAT_AW-1:0]    feat_addr,
  output logic [SV_AW-1:0]      sv_addr,
  output logic                  mac_vld,
  output logic                  accum_clr,
  output logic                  stg_en,
  input  logic [DATA_WIDTH-1:0] accum_data_in,
  input  logic                  accum_data_vld,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [SV_AW-1:0]      res_sv_idx,
  output logic                  res_vld,
  input  logic                  res_rdy
`ifdef SVM_ACCUM_CTRL_WDOG_EN
  ,
  output logic                  err
`endif
);
  localparam int DRN_W = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAIT_ACC, OUTPUT, DONE} state_t;
  state_t state, state_nxt;

  logic [FEAT_W-1:0] n_feat, cfg_feat;
  logic [SV_W-1:0]   n_sv, cfg_sv;
  logic [DRN_W-1:0]  drain_cnt;
  logic              feat_last, sv_last, drain_last, acc_to;

  // Zero features still means one issue; anything past the array size is clamped.
  always_comb begin
    cfg_feat = cfg_num_feat;
    if (cfg_num_feat == '0) cfg_feat = FEAT_W'(1);
    else if (cfg_num_feat > FEAT_W'(NUM_FEAT)) cfg_feat = FEAT_W'(NUM_FEAT);
    cfg_sv = cfg_num_sv;
    if (cfg_num_sv > SV_W'(NUM_SV)) cfg_sv = SV_W'(NUM_SV);
  end

  assign feat_last  = FEAT_W'(feat_addr) == n_feat - FEAT_W'(1);
  assign sv_last    = SV_W'(sv_addr) == n_sv - SV_W'(1);
  assign drain_last = drain_cnt == DRN_W'(MAC_LAT);

`ifdef SVM_ACCUM_CTRL_WDOG_EN
  logic [3:0] wd_cnt;
  assign acc_to = (wd_cnt == 4'd7) && !accum_data_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state == IDLE && start) err <= 1'b0;
      else if (state == WAIT_ACC && acc_to) err <= 1'b1;
      if (state == WAIT_ACC) wd_cnt <= wd_cnt + 4'd1;
      else                   wd_cnt <= '0;
    end
  end
`else
  assign acc_to = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mac_vld   = 1'b0;
    accum_clr = 1'b0;
    stg_en    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:     if (start) state_nxt = (cfg_sv == '0) ? DONE : ISSUE;
      ISSUE: begin
        mac_vld   = 1'b1;
        accum_clr = feat_addr == '0;
        if (feat_last) state_nxt = DRAIN;
      end
      DRAIN: if (drain_last) begin
        stg_en    = 1'b1;
        state_nxt = WAIT_ACC;
      end
      WAIT_ACC: begin
        if (accum_data_vld) state_nxt = OUTPUT;
        else if (acc_to)    state_nxt = IDLE;
      end
      OUTPUT:   if (res_vld && res_rdy) state_nxt = sv_last ? DONE : ISSUE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  assign busy = state != IDLE;

  // Address counters hold at their terminal values until the FSM moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_feat     <= '0;
      n_sv       <= '0;
      feat_addr  <= '0;
      sv_addr    <= '0;
      drain_cnt  <= '0;
      res_data   <= '0;
      res_sv_idx <= '0;
      res_vld    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n_feat    <= cfg_feat;
          n_sv      <= cfg_sv;
          feat_addr <= '0;
          sv_addr   <= '0;
        end
        ISSUE: begin
          drain_cnt <= '0;
          if (!feat_last) feat_addr <= feat_addr + FEAT_AW'(1);
        end
        DRAIN: if (!drain_last) drain_cnt <= drain_cnt + DRN_W'(1);
        WAIT_ACC: if (accum_data_vld) begin
          res_data   <= accum_data_in;
          res_sv_idx <= sv_addr;
          res_vld    <= 1'b1;
        end
        OUTPUT: if (res_vld && res_rdy) begin
          res_vld <= 1'b0;
          if (!sv_last) begin
            sv_addr   <= sv_addr + SV_AW'(1);
            feat_addr <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_svm_accum_ctrl.sv
// Randomized bench for svm_accum_ctrl: reference sums/issue order per run vs. an accumulator stand-in driven from DUT addresses.
module tb_svm_accum_ctrl;
  localparam int DW = 32, NF = 16, NSV = 8, ML = 2;
  localparam int FEAT_W = $clog2(NF + 1), FEAT_AW = $clog2(NF);
  localparam int SV_W = $clog2(NSV + 1), SV_AW = $clog2(NSV);

  typedef struct packed { int sv; int f; } iss_t;

  logic               clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [FEAT_W-1:0]  cfg_num_feat = '0;
  logic [SV_W-1:0]    cfg_num_sv = '0;
  logic               busy, done, mac_vld, accum_clr, stg_en, res_vld;
  logic [FEAT_AW-1:0] feat_addr;
  logic [SV_AW-1:0]   sv_addr, res_sv_idx;
  logic [DW-1:0]      accum_data_in = '0, res_data;
  logic               accum_data_vld = 1'b0, res_rdy = 1'b0;
`ifdef SVM_ACCUM_CTRL_WDOG_EN
  logic               err;
`endif

  logic [DW-1:0] w [NSV][NF];
  int checks = 0, errors = 0;

  svm_accum_ctrl #(.DATA_WIDTH(DW), .NUM_FEAT(NF), .NUM_SV(NSV), .MAC_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_feat(cfg_num_feat), .cfg_num_sv(cfg_num_sv),
    .busy(busy), .done(done), .feat_addr(feat_addr), .sv_addr(sv_addr), .mac_vld(mac_vld),
    .accum_clr(accum_clr), .stg_en(stg_en), .accum_data_in(accum_data_in),
    .accum_data_vld(accum_data_vld), .res_data(res_data), .res_sv_idx(res_sv_idx),
    .res_vld(res_vld), .res_rdy(res_rdy)
`ifdef SVM_ACCUM_CTRL_WDOG_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ctl"}, {mac_vld, accum_clr, stg_en, res_vld}, 0);
    chk({tag, "_addr"}, {feat_addr, sv_addr, res_sv_idx}, 0);
    chk({tag, "_data"}, res_data, 0);
  endtask

  // One full run: expectations come from the clamped config alone.
  task automatic run(input int nf_cfg, input int nsv_cfg, input int bp, input int rdy_pct,
                     input int max_dly, input bit spur, input bit spam);
    int nf, nsv, cyc, last_mac, res_n, stg_n, dly, hold;
    bit pend, timed, fin;
    logic [DW-1:0] acc, sum;
    iss_t e;
    iss_t iss_q[$];
    logic [DW-1:0] res_q[$];
    int idx_q[$];
    nf    = (nf_cfg == 0) ? 1 : ((nf_cfg > NF) ? NF : nf_cfg);
    nsv   = (nsv_cfg > NSV) ? NSV : nsv_cfg;
    timed = (bp == 0) && (rdy_pct >= 100) && (max_dly == 0);
    for (int s = 0; s < NSV; s++)
      for (int f = 0; f < NF; f++) w[s][f] = $urandom();
    for (int s = 0; s < nsv; s++) begin
      sum = '0;
      for (int f = 0; f < nf; f++) begin
        sum += w[s][f];
        e.sv = s; e.f = f;
        iss_q.push_back(e);
      end
      res_q.push_back(sum);
      idx_q.push_back(s);
    end
    cyc = 0; last_mac = 0; res_n = 0; stg_n = 0; dly = 0; hold = 0;
    pend = 1'b0; fin = 1'b0; acc = '0;
    @(negedge clk);
    start = 1'b1;
    cfg_num_feat = FEAT_W'(nf_cfg);
    cfg_num_sv   = SV_W'(nsv_cfg);
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      accum_data_vld = 1'b0;
      chk("excl", mac_vld & stg_en, 0);
      if (mac_vld) begin
        last_mac = cyc;
        if (iss_q.size() == 0) chk("mac_extra", 1, 0);
        else begin
          e = iss_q.pop_front();
          chk("sv_addr", sv_addr, e.sv);
          chk("feat_addr", feat_addr, e.f);
          chk("accum_clr", accum_clr, e.f == 0);
        end
        acc = accum_clr ? w[sv_addr][feat_addr] : acc + w[sv_addr][feat_addr];
      end else chk("clr_idle", accum_clr, 0);
      if (pend) begin
        if (dly == 0) begin
          accum_data_vld = 1'b1;
          accum_data_in  = acc;
          pend = 1'b0;
        end else dly--;
      end
      if (stg_en) begin
        stg_n++;
        chk("stg_gap", cyc - last_mac, ML + 1);
        pend = 1'b1;
        dly  = $urandom_range(0, max_dly);
      end
      if (spur && mac_vld && $urandom_range(0, 1) == 1) begin
        accum_data_vld = 1'b1;
        accum_data_in  = $urandom();
      end
      if (res_vld) begin
        chk("res_mac", mac_vld, 0);
        if (res_q.size() == 0) chk("res_extra", 1, 0);
        else begin
          chk("res_data", res_data, res_q[0]);
          chk("res_idx", res_sv_idx, idx_q[0]);
        end
        if (hold < bp) begin
          res_rdy = 1'b0;
          hold++;
        end else res_rdy = ($urandom_range(1, 100) <= rdy_pct);
        if (res_rdy) begin
          hold = 0;
          res_n++;
          if (res_q.size() > 0) begin
            void'(res_q.pop_front());
            void'(idx_q.pop_front());
          end
        end
      end else res_rdy = ($urandom_range(0, 1) == 1);
      if (done) begin
        fin = 1'b1;
        chk("done_busy", busy, 1);
        if (timed) chk("run_cycles", cyc, nsv * (nf + ML + 3) + 1);
        chk("mac_left", iss_q.size(), 0);
        chk("res_cnt", res_n, nsv);
        chk("stg_cnt", stg_n, nsv);
      end else if (spam) start = ($urandom_range(0, 3) == 0);
      cfg_num_feat = FEAT_W'($urandom());
      cfg_num_sv   = SV_W'($urandom());
    end
    if (!fin) chk("timeout", 0, 1);
    start = 1'b0; res_rdy = 1'b0; accum_data_vld = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  task automatic reset_mid();
    int dn;
    dn = 0;
    @(negedge clk);
    start = 1'b1; cfg_num_feat = FEAT_W'(6); cfg_num_sv = SV_W'(3);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_pre_mac", mac_vld, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero_outs("rst_mid");
    repeat (40) begin
      @(negedge clk);
      if (done || mac_vld) dn++;
    end
    chk("rst_no_done", dn, 0);
  endtask

`ifdef SVM_ACCUM_CTRL_WDOG_EN
  task automatic wdog_test();
    int s, cyc, bad;
    s = -1; cyc = 0; bad = 0;
    accum_data_vld = 1'b0; res_rdy = 1'b1;
    @(negedge clk);
    start = 1'b1; cfg_num_feat = FEAT_W'(2); cfg_num_sv = SV_W'(1);
    while (cyc < 100) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (stg_en) s = cyc;
      if (done || res_vld) bad++;
      if (s >= 0 && cyc == s + 8) chk("wd_err_early", err, 0);
      if (s >= 0 && cyc == s + 9) begin
        chk("wd_err", err, 1);
        chk("wd_idle", busy, 0);
        break;
      end
    end
    chk("wd_stg_seen", s >= 0, 1);
    chk("wd_no_done", bad, 0);
    start = 1'b1; cfg_num_feat = FEAT_W'(1); cfg_num_sv = SV_W'(1);
    @(negedge clk);
    start = 1'b0;
    chk("wd_clr", err, 0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wd_rst_err", err, 0);
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
    rst = 1'b0;
    run(4, 2, 0, 100, 0, 1'b0, 1'b0);
    run(4, 2, 5, 100, 0, 1'b0, 1'b0);
    run(0, 3, 0, 100, 0, 1'b0, 1'b0);
    run(31, 2, 0, 100, 0, 1'b0, 1'b0);
    run(5, 0, 0, 100, 0, 1'b0, 1'b0);
    run(15, 9, 0, 100, 0, 1'b0, 1'b0);
    run(3, 2, 0, 100, 0, 1'b1, 1'b1);
    reset_mid();
    for (int i = 0; i < 16; i++)
      run($urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 3),
          $urandom_range(30, 100), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`ifdef SVM_ACCUM_CTRL_WDOG_EN
    wdog_test();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
